// File: rtl/data_ram_dp.sv
// Dual-port, byte-enabled synchronous data RAM with 1- or 2-cycle read latency and per-port read-valid.
// Define DATA_RAM_DP_FWD_EN to forward a same-edge write on one port into a read of that word on the other port.
module data_ram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    ce_1,
  input  logic                    we_1,
  input  logic [ADDR_WIDTH-1:0]   addr_1,
  input  logic [DATA_WIDTH/8-1:0] sel_1,
  input  logic [DATA_WIDTH-1:0]   wdata_1,
  output logic [DATA_WIDTH-1:0]   rdata_1,
  output logic                    rvalid_1,

  input  logic                    ce_2,
  input  logic                    we_2,
  input  logic [ADDR_WIDTH-1:0]   addr_2,
  input  logic [DATA_WIDTH/8-1:0] sel_2,
  input  logic [DATA_WIDTH-1:0]   wdata_2,
  output logic [DATA_WIDTH-1:0]   rdata_2,
  output logic                    rvalid_2
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int IDX   = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX-1:0]        idx_1, idx_2;
  logic                  wr_1, wr_2;
  logic                  rd_1, rd_2;
  logic [DATA_WIDTH-1:0] rd_word_1, rd_word_2;
  logic                  unused_addr;

  // Byte offset and bits above the index are ignored, so addresses alias modulo DEPTH words.
  assign idx_1       = addr_1[OFF+IDX-1:OFF];
  assign idx_2       = addr_2[OFF+IDX-1:OFF];
  assign unused_addr = ^{addr_1, addr_2};

  assign wr_1 = ce_1 & we_1;
  assign wr_2 = ce_2 & we_2;
  assign rd_1 = ce_1 & ~we_1;
  assign rd_2 = ce_2 & ~we_2;

  // Port 2 lanes are scheduled before port 1 so port 1 takes any lane both ports enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_2 && sel_2[b]) mem[idx_2][8*b +: 8] <= wdata_2[8*b +: 8];
        if (wr_1 && sel_1[b]) mem[idx_1][8*b +: 8] <= wdata_1[8*b +: 8];
      end
    end
  end

`ifdef DATA_RAM_DP_FWD_EN
  // A read sees the lanes the other port writes to the same word on this edge.
  always_comb begin
    rd_word_1 = mem[idx_1];
    rd_word_2 = mem[idx_2];
    if (wr_2 && (idx_2 == idx_1)) begin
      for (int b = 0; b < LANES; b++) begin
        if (sel_2[b]) rd_word_1[8*b +: 8] = wdata_2[8*b +: 8];
      end
    end
    if (wr_1 && (idx_1 == idx_2)) begin
      for (int b = 0; b < LANES; b++) begin
        if (sel_1[b]) rd_word_2[8*b +: 8] = wdata_1[8*b +: 8];
      end
    end
  end
`else
  assign rd_word_1 = mem[idx_1];
  assign rd_word_2 = mem[idx_2];
`endif

  logic [DATA_WIDTH-1:0] s1_data_1, s1_data_2;
  logic                  s1_valid_1, s1_valid_2;

  // Array read register; an idle port pushes a zero word, a write slot carries a don't-care word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_1  <= '0;
      s1_data_2  <= '0;
      s1_valid_1 <= 1'b0;
      s1_valid_2 <= 1'b0;
    end else begin
      s1_data_1  <= ce_1 ? rd_word_1 : '0;
      s1_data_2  <= ce_2 ? rd_word_2 : '0;
      s1_valid_1 <= rd_1;
      s1_valid_2 <= rd_2;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data_1, s2_data_2;
      logic                  s2_valid_1, s2_valid_2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data_1  <= '0;
          s2_data_2  <= '0;
          s2_valid_1 <= 1'b0;
          s2_valid_2 <= 1'b0;
        end else begin
          s2_data_1  <= s1_data_1;
          s2_data_2  <= s1_data_2;
          s2_valid_1 <= s1_valid_1;
          s2_valid_2 <= s1_valid_2;
        end
      end

      assign rdata_1  = s2_data_1;
      assign rdata_2  = s2_data_2;
      assign rvalid_1 = s2_valid_1;
      assign rvalid_2 = s2_valid_2;
    end else begin : g_lat1
      assign rdata_1  = s1_data_1;
      assign rdata_2  = s1_data_2;
      assign rvalid_1 = s1_valid_1;
      assign rvalid_2 = s1_valid_2;
    end
  endgenerate

endmodule

// File: tb/tb_data_ram_dp.sv
// Self-checking bench for data_ram_dp: one latency-1/1024-word instance and one latency-2/16-word
// instance share stimulus and are each compared against an array-based reference model.
module tb_data_ram_dp;

  localparam int DEP0 = 1024;
  localparam int DEP1 = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_1, we_1, ce_2, we_2;
  logic [31:0] addr_1, addr_2;
  logic [3:0]  sel_1, sel_2;
  logic [31:0] wdata_1, wdata_2;

  logic [31:0] rdata_a1, rdata_a2, rdata_b1, rdata_b2;
  logic        rvalid_a1, rvalid_a2, rvalid_b1, rvalid_b2;

  always #5 clk = ~clk;

  data_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEP0), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ce_1(ce_1), .we_1(we_1), .addr_1(addr_1), .sel_1(sel_1), .wdata_1(wdata_1),
    .rdata_1(rdata_a1), .rvalid_1(rvalid_a1),
    .ce_2(ce_2), .we_2(we_2), .addr_2(addr_2), .sel_2(sel_2), .wdata_2(wdata_2),
    .rdata_2(rdata_a2), .rvalid_2(rvalid_a2)
  );

  data_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEP1), .RD_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ce_1(ce_1), .we_1(we_1), .addr_1(addr_1), .sel_1(sel_1), .wdata_1(wdata_1),
    .rdata_1(rdata_b1), .rvalid_1(rvalid_b1),
    .ce_2(ce_2), .we_2(we_2), .addr_2(addr_2), .sel_2(sel_2), .wdata_2(wdata_2),
    .rdata_2(rdata_b2), .rvalid_2(rvalid_b2)
  );

  // Observed outputs indexed [instance][port]
  logic        gv [2][2];
  logic [31:0] gd [2][2];
  assign gv[0][0] = rvalid_a1;
  assign gv[0][1] = rvalid_a2;
  assign gv[1][0] = rvalid_b1;
  assign gv[1][1] = rvalid_b2;
  assign gd[0][0] = rdata_a1;
  assign gd[0][1] = rdata_a2;
  assign gd[1][0] = rdata_b1;
  assign gd[1][1] = rdata_b2;

  // Reference model: word arrays plus expected output and mid-pipeline slots
  logic [31:0] mm [2][DEP0];
  logic        ev [2][2];
  logic [31:0] ed [2][2];
  logic        ec [2][2];
  logic        mv [2][2];
  logic [31:0] md [2][2];
  logic        mc [2][2];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [31:0] cross_exp;

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    ce_1 = 0; we_1 = 0; addr_1 = 0; sel_1 = 0; wdata_1 = 0;
    ce_2 = 0; we_2 = 0; addr_2 = 0; sel_2 = 0; wdata_2 = 0;
  endtask

  task automatic clear_model_pipes();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        ev[i][p] = 0; ed[i][p] = 0; ec[i][p] = 1;
        mv[i][p] = 0; md[i][p] = 0; mc[i][p] = 1;
      end
  endtask

  task automatic set_reset(input logic v);
    rst_n = v;
    if (!v) clear_model_pipes();
  endtask

  // One clock edge: model computes from current inputs, then outputs are sampled 1 time unit after the edge.
  task automatic advance();
    logic        nv [2][2];
    logic [31:0] nd [2][2];
    logic        nc [2][2];
    int          dep, i1, i2;
    logic [31:0] old1, old2, r1, r2;
    logic        wr1, wr2;
    wr1 = ce_1 && we_1;
    wr2 = ce_2 && we_2;
    for (int i = 0; i < 2; i++) begin
      dep  = (i == 0) ? DEP0 : DEP1;
      i1   = int'((addr_1 >> 2) % dep);
      i2   = int'((addr_2 >> 2) % dep);
      old1 = mm[i][i1];
      old2 = mm[i][i2];
      if (rst_n) begin
        if (wr2) mm[i][i2] = merge(mm[i][i2], wdata_2, sel_2);
        if (wr1) mm[i][i1] = merge(mm[i][i1], wdata_1, sel_1);
      end
      r1 = old1;
      r2 = old2;
`ifdef DATA_RAM_DP_FWD_EN
      if (wr2 && i1 == i2) r1 = mm[i][i1];
      if (wr1 && i1 == i2) r2 = mm[i][i2];
`endif
      nv[i][0] = rst_n && ce_1 && !we_1;
      nv[i][1] = rst_n && ce_2 && !we_2;
      nc[i][0] = !rst_n || !wr1;
      nc[i][1] = !rst_n || !wr2;
      nd[i][0] = (rst_n && ce_1) ? r1 : 32'h0;
      nd[i][1] = (rst_n && ce_2) ? r2 : 32'h0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) clear_model_pipes();
    else
      for (int p = 0; p < 2; p++) begin
        ev[0][p] = nv[0][p]; ed[0][p] = nd[0][p]; ec[0][p] = nc[0][p];
        ev[1][p] = mv[1][p]; ed[1][p] = md[1][p]; ec[1][p] = mc[1][p];
        mv[1][p] = nv[1][p]; md[1][p] = nd[1][p]; mc[1][p] = nc[1][p];
      end
  endtask

  task automatic init_memory();
    for (int w = 0; w < DEP0; w += 2) begin
      ce_1 = 1; we_1 = 1; sel_1 = 4'hF; addr_1 = w * 4;       wdata_1 = 0;
      ce_2 = 1; we_2 = 1; sel_2 = 4'hF; addr_2 = (w + 1) * 4; wdata_2 = 0;
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_reset();
    idle_inputs();
    ce_1 = 1; we_1 = 1; addr_1 = 32'h100; sel_1 = 4'hF; wdata_1 = 32'hCAFEF00D;
    advance();
    idle_inputs();
    set_reset(1'b0);
    #1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (gd[i][p] !== 32'h0 || gv[i][p] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL reset_entry inst%0d port%0d: got data %h valid %b, want 0/0",
                   i, p, gd[i][p], gv[i][p]);
        end
      end
    ce_1 = 1; we_1 = 1; addr_1 = 32'h100; sel_1 = 4'hF; wdata_1 = 32'hFFFFFFFF;
    ce_2 = 1; we_2 = 1; addr_2 = 32'h104; sel_2 = 4'hF; wdata_2 = 32'hFFFFFFFF;
    repeat (3) begin
      advance();
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          vectors++;
          if (gd[i][p] !== 32'h0 || gv[i][p] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold inst%0d port%0d cyc%0d: got data %h valid %b, want 0/0",
                     i, p, cyc, gd[i][p], gv[i][p]);
          end
        end
    end
    idle_inputs();
    set_reset(1'b1);
    ce_1 = 1; addr_1 = 32'h100;
    advance();
    idle_inputs();
    vectors++;
    if (gv[0][0] !== 1'b1 || gd[0][0] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("[TB] FAIL reset_retain_a: got %h valid %b, want cafef00d valid 1", gd[0][0], gv[0][0]);
    end
    advance();
    vectors++;
    if (gv[1][0] !== 1'b1 || gd[1][0] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("[TB] FAIL reset_retain_b: got %h valid %b, want cafef00d valid 1", gd[1][0], gv[1][0]);
    end
  endtask

  task automatic test_byte_lanes();
    idle_inputs();
    ce_1 = 1; we_1 = 1; addr_1 = 32'h100; sel_1 = 4'b1111; wdata_1 = 32'h11223344;
    advance();
    vectors++;
    if (gv[0][0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL write_no_rvalid: got %b want 0", gv[0][0]);
    end
    sel_1 = 4'b0101; wdata_1 = 32'hAABBCCDD;
    advance();
    we_1 = 0; sel_1 = 0; wdata_1 = 0;
    advance();
    idle_inputs();
    vectors++;
    if (gv[0][0] !== 1'b1 || gd[0][0] !== 32'h11BB33DD) begin
      miscompares++;
      $display("[TB] FAIL byte_lanes_a: got %h valid %b, want 11bb33dd valid 1", gd[0][0], gv[0][0]);
    end
    advance();
    vectors++;
    if (gv[0][0] !== 1'b0 || gd[0][0] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL byte_lanes_pulse: got %h valid %b, want 0 valid 0", gd[0][0], gv[0][0]);
    end
    vectors++;
    if (gv[1][0] !== 1'b1 || gd[1][0] !== 32'h11BB33DD) begin
      miscompares++;
      $display("[TB] FAIL byte_lanes_b: got %h valid %b, want 11bb33dd valid 1", gd[1][0], gv[1][0]);
    end
    advance();
  endtask

  task automatic test_collision();
    idle_inputs();
    ce_1 = 1; we_1 = 1; addr_1 = 32'h40; sel_1 = 4'hF; wdata_1 = 32'h12345678;
    advance();
    sel_1 = 4'b0011; wdata_1 = 32'hFFFFFFFF;
    ce_2 = 1; we_2 = 1; addr_2 = 32'h40; sel_2 = 4'b0110; wdata_2 = 32'h00000000;
    advance();
    idle_inputs();
    ce_2 = 1; addr_2 = 32'h40;
    advance();
    idle_inputs();
    vectors++;
    if (gv[0][1] !== 1'b1 || gd[0][1] !== 32'h1200FFFF) begin
      miscompares++;
      $display("[TB] FAIL collision_a: got %h valid %b, want 1200ffff valid 1", gd[0][1], gv[0][1]);
    end
    advance();
    vectors++;
    if (gv[1][1] !== 1'b1 || gd[1][1] !== 32'h1200FFFF) begin
      miscompares++;
      $display("[TB] FAIL collision_b: got %h valid %b, want 1200ffff valid 1", gd[1][1], gv[1][1]);
    end
    advance();
  endtask

  task automatic test_cross_port();
    idle_inputs();
    ce_1 = 1; we_1 = 1; addr_1 = 32'h80; sel_1 = 4'hF; wdata_1 = 32'h0;
    advance();
    wdata_1 = 32'hDEADBEEF;
    ce_2 = 1; we_2 = 0; addr_2 = 32'h80;
    advance();
    idle_inputs();
`ifdef DATA_RAM_DP_FWD_EN
    cross_exp = 32'hDEADBEEF;
`else
    cross_exp = 32'h00000000;
`endif
    vectors++;
    if (gv[0][1] !== 1'b1 || gd[0][1] !== cross_exp) begin
      miscompares++;
      $display("[TB] FAIL cross_p1w_p2r_a: got %h valid %b, want %h valid 1", gd[0][1], gv[0][1], cross_exp);
    end
    advance();
    vectors++;
    if (gv[1][1] !== 1'b1 || gd[1][1] !== cross_exp) begin
      miscompares++;
      $display("[TB] FAIL cross_p1w_p2r_b: got %h valid %b, want %h valid 1", gd[1][1], gv[1][1], cross_exp);
    end
    ce_2 = 1; we_2 = 1; addr_2 = 32'h80; sel_2 = 4'b1100; wdata_2 = 32'h0BADF00D;
    ce_1 = 1; we_1 = 0; addr_1 = 32'h80;
    advance();
    idle_inputs();
`ifdef DATA_RAM_DP_FWD_EN
    cross_exp = 32'h0BADBEEF;
`else
    cross_exp = 32'hDEADBEEF;
`endif
    vectors++;
    if (gv[0][0] !== 1'b1 || gd[0][0] !== cross_exp) begin
      miscompares++;
      $display("[TB] FAIL cross_p2w_p1r: got %h valid %b, want %h valid 1", gd[0][0], gv[0][0], cross_exp);
    end
    advance();
    advance();
  endtask

  task automatic test_alias_latency();
    idle_inputs();
    ce_2 = 1; we_2 = 1; addr_2 = 32'h0; sel_2 = 4'hF; wdata_2 = 32'h5A5AC3C3;
    advance();
    idle_inputs();
    ce_1 = 1; addr_1 = 32'h0;
    advance();
    vectors++;
    if (gv[1][0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alias_early: got valid %b want 0", gv[1][0]);
    end
    addr_1 = 32'h40;
    advance();
    idle_inputs();
    vectors++;
    if (gv[1][0] !== 1'b1 || gd[1][0] !== 32'h5A5AC3C3) begin
      miscompares++;
      $display("[TB] FAIL alias_first: got %h valid %b, want 5a5ac3c3 valid 1", gd[1][0], gv[1][0]);
    end
    advance();
    vectors++;
    if (gv[1][0] !== 1'b1 || gd[1][0] !== 32'h5A5AC3C3) begin
      miscompares++;
      $display("[TB] FAIL alias_second: got %h valid %b, want 5a5ac3c3 valid 1", gd[1][0], gv[1][0]);
    end
    advance();
    vectors++;
    if (gv[1][0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alias_end: got valid %b want 0", gv[1][0]);
    end
  endtask

  task automatic test_reset_mid_read();
    idle_inputs();
    ce_1 = 1; addr_1 = 32'h0;
    advance();
    idle_inputs();
    set_reset(1'b0);
    #1;
    vectors++;
    if (gv[1][0] !== 1'b0 || gd[1][0] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_now: got %h valid %b, want 0 valid 0", gd[1][0], gv[1][0]);
    end
    repeat (2) advance();
    set_reset(1'b1);
    repeat (2) begin
      advance();
      vectors++;
      if (gv[1][0] !== 1'b0 || gv[0][0] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mid_reset_after cyc%0d: got valid a %b b %b, want 0 0", cyc, gv[0][0], gv[1][0]);
      end
    end
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 400; n++) begin
      w = int'($urandom_range(0, 7)) + ($urandom_range(0, 1) == 1 ? 16 : 0);
      ce_1 = $urandom_range(0, 3) != 0; we_1 = $urandom_range(0, 1) == 1;
      addr_1 = ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | ($urandom & 32'h3);
      sel_1 = 4'($urandom); wdata_1 = $urandom;
      w = int'($urandom_range(0, 7)) + ($urandom_range(0, 1) == 1 ? 16 : 0);
      ce_2 = $urandom_range(0, 3) != 0; we_2 = $urandom_range(0, 1) == 1;
      addr_2 = ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | ($urandom & 32'h3);
      sel_2 = 4'($urandom); wdata_2 = $urandom;
      advance();
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          vectors++;
          if (gv[i][p] !== ev[i][p]) begin
            miscompares++;
            $display("[TB] FAIL rand_rvalid inst%0d port%0d cyc%0d: got %b want %b",
                     i, p, cyc, gv[i][p], ev[i][p]);
          end
          if (ec[i][p]) begin
            vectors++;
            if (gd[i][p] !== ed[i][p]) begin
              miscompares++;
              $display("[TB] FAIL rand_rdata inst%0d port%0d cyc%0d: got %h want %h",
                       i, p, cyc, gd[i][p], ed[i][p]);
            end
          end
        end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    set_reset(1'b0);
    repeat (2) advance();
    set_reset(1'b1);
    init_memory();
    test_reset();
    test_byte_lanes();
    test_collision();
    test_cross_port();
    test_alias_latency();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_ram_dp.md
# data_ram_dp

Parametrised dual-port, byte-enabled synchronous data RAM for the data-side memory stage, replacing the fixed 32-bit, two-port word store. Both ports can read or write every cycle. The block adds configurable read latency, a per-port read-valid strobe and a defined same-cycle collision policy. Optional write-to-read forwarding across ports is compiled in by macro.

## Interface
- DATA_WIDTH, 32, data bits per word; multiple of 8, 32 or 64
- ADDR_WIDTH, 32, byte-address width
- DEPTH, 1024, words per port space; power of 2
- RD_LATENCY, 1, cycles from accepted read to `rdata_p`; legal values 1 or 2
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- ce_p  in  1  port p enable, p ∈ {1,2}
- we_p  in  1  port p write enable; ignored unless `ce_p` is high
- addr_p  in  ADDR_WIDTH  port p byte address
- sel_p  in  DATA_WIDTH/8  port p byte enables; bit i covers byte i
- wdata_p  in  DATA_WIDTH  port p write data
- rdata_p  out  DATA_WIDTH  port p read data
- rvalid_p  out  1  port p read-data-valid strobe

## Operation
- Word index = `addr_p[OFF+IDX-1:OFF]`, where OFF = log2(DATA_WIDTH/8) and IDX = log2(DEPTH). Upper address bits are ignored, so addresses alias modulo DEPTH words.
- **Storage:** DATA_WIDTH/8 byte lanes. Array contents are not reset; simulation initial value is X.
- **Read:** `ce_p`=1 and `we_p`=0.
  - The word is captured at the edge.
  - Data emerges after RD_LATENCY edges with `rvalid_p`=1 for exactly one cycle.
- **Write:** `ce_p`=1 and `we_p`=1.
  - Lanes with `sel_p[i]`=1 are updated at the edge.
  - The same port also performs a read of the old word (read-first). `rvalid_p` is not asserted for writes, and `rdata_p` is don't-care in that slot.
- **Idle port:** `ce_p`=0. A zero word enters the port's pipeline and `rvalid_p`=0.
- **Same word, both ports writing, same edge:** per byte lane, port 1 wins where both `sel` bits are set. Lanes enabled by only one port take that port's data. No X corruption is allowed.
- **Same word, one port writes, the other reads, same edge:** forwarding behaviour depends on the macro (see Configuration).
- **Pipeline:**
  - RD_LATENCY=1: array read register only.
  - RD_LATENCY=2: adds an output register stage. The stage is always advancing, with no stall input.

## Timing
- **Reset:** while `rst_n`=0, `rdata_1`, `rdata_2` = 0, `rvalid_1`, `rvalid_2` = 0, all pipeline stages are cleared, and no array writes commit.
- **Reset release:** the first accepted request is at the first rising edge with `rst_n`=1.
- **Reset mid-operation:** in-flight reads are discarded and their `rvalid` is never raised. Writes committed before the reset edge are retained.
- **Read latency:** a request at edge N gives data and `rvalid` valid after edge N+RD_LATENCY-1+1, i.e. visible in the cycle following edge N (latency 1) or N+1 (latency 2).
- **Throughput:** one access per port per cycle, sustained indefinitely.
- **Same-port back-to-back:** write then read of the same word at consecutive edges returns the new data.

## Configuration
- **Macro:** `DATA_RAM_DP_FWD_EN`.
- **Defined:** a read on one port to the word written by the other port at the same edge returns the post-write word. That is the new bytes for lanes written, old bytes elsewhere, with port-1-wins merge if both ports write. Implemented by comparing indices and muxing at the read register.
- **Undefined:** such a read returns the pre-write word (read-first). No comparator logic is present.
- Same-port behaviour is read-first in both builds.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `ce_1`=`ce_2`=1 → `rdata`=0, `rvalid`=0 throughout; array unchanged.
- **Byte-lane write, DATA_WIDTH=32, RD_LATENCY=1:** write 0x11223344 to 0x100 with sel=4'b1111, then 0xAABBCCDD with sel=4'b0101 → a read of 0x100 returns 0x11BB33DD one cycle later, with `rvalid_1` pulsed once.
- **Dual-write collision:** port 1 writes 0xFFFFFFFF sel=4'b0011 and port 2 writes 0x00000000 sel=4'b0110 to 0x40 on the same edge, from a word of 0x12345678 → a read returns 0x1200FFFF (lane 1 to port 1).
- **Cross-port read/write on the same edge:** port 1 writes 0xDEADBEEF to 0x80 (old value 0x0) while port 2 reads 0x80 → with `DATA_RAM_DP_FWD_EN`: 0xDEADBEEF; without: 0x00000000.
- **RD_LATENCY=2, DEPTH=16:** reads issued to 0x0 and 0x40 (aliasing) on consecutive edges → both return the same word, two cycles after issue, with `rvalid` high in two consecutive cycles.
- **Reset mid-read:** issue a read at RD_LATENCY=2, then assert `rst_n` low one cycle later → `rvalid` never asserts for that read, and `rdata`=0 immediately.
